// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared types and constants for the bus transfer sequencer: select width,
// sequencer state encoding and the queued request layout.
package bus_pkg;

    localparam int BUS_SEL_W = 5;
    localparam int BUS_NDST  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LOAD
    } bus_state_e;

    typedef struct packed {
        logic [BUS_SEL_W-1:0] src;
        logic [BUS_NDST-1:0]  dst;
    } bus_req_t;

endpackage

// File: rtl/bus_transfer_sequencer_fifo.sv
// Circular request FIFO with a separate occupancy counter and a synchronous
// flush that discards the contents and any concurrent push.
module bus_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                   clk_i,
    input  logic                   clr_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Plays queued register transfers onto the 32:1 datapath bus: one cycle of
// select settling (DRIVE) followed by a one-cycle load-enable pulse (LOAD).
module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NDST  = BUS_NDST
) (
    input  logic                   clk_i,
    input  logic                   clr_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [BUS_SEL_W-1:0]   req_src_i,
    input  logic [NDST-1:0]        req_dst_i,
    input  logic                   flush_i,
    output logic [BUS_SEL_W-1:0]   bus_sel_o,
    output logic [NDST-1:0]        dst_load_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] pending_o
);

    typedef struct packed {
        logic [BUS_SEL_W-1:0] src;
        logic [NDST-1:0]      dst;
    } req_t;

    bus_state_e           state_q, state_d;
    logic [BUS_SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic [NDST-1:0]      dst_load_q, dst_load_d;
    logic [NDST-1:0]      cur_dst_q, cur_dst_d;
    logic                 busy_q, busy_d;

    req_t                 fifo_in;
    req_t                 fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 push;
    logic                 pop;

    assign req_ready_o = !fifo_full;
    assign fifo_in     = '{src: req_src_i, dst: req_dst_i};
    // Zero-destination requests are acknowledged but never occupy a slot.
    assign push        = req_valid_i && !fifo_full && (req_dst_i != '0) && !flush_i;
    assign pop         = !flush_i && !fifo_empty && (state_q != ST_DRIVE);

    bus_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .clr_n_i (clr_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_i  (fifo_in),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        bus_sel_d  = bus_sel_q;
        dst_load_d = '0;
        cur_dst_d  = cur_dst_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (pop) begin
                    state_d   = ST_DRIVE;
                    bus_sel_d = fifo_head.src;
                    cur_dst_d = fifo_head.dst;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_d    = ST_LOAD;
                dst_load_d = cur_dst_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d    = ST_IDLE;
            dst_load_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q    <= ST_IDLE;
            bus_sel_q  <= '0;
            dst_load_q <= '0;
            cur_dst_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_sel_q  <= bus_sel_d;
            dst_load_q <= dst_load_d;
            cur_dst_q  <= cur_dst_d;
            busy_q     <= busy_d;
        end
    end

    assign bus_sel_o  = bus_sel_q;
    assign dst_load_o = dst_load_q;
    assign busy_o     = busy_q;
    assign pending_o  = fifo_count;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed self-checking bench for bus_transfer_sequencer with hand-computed
// cycle-by-cycle expectations.
module tb_bus_transfer_sequencer;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [31:0] req_dst;
    logic        flush;
    logic [4:0]  bus_sel;
    logic [31:0] dst_load;
    logic        busy;
    logic [2:0]  pending;

    int checkCount = 0;
    int passCount  = 0;

    bus_transfer_sequencer #(.DEPTH(4), .NDST(32)) dut (
        .clk_i       (clk),
        .clr_n_i     (clr_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_src_i   (req_src),
        .req_dst_i   (req_dst),
        .flush_i     (flush),
        .bus_sel_o   (bus_sel),
        .dst_load_o  (dst_load),
        .busy_o      (busy),
        .pending_o   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] s,
                                 input logic [31:0] d, input logic f);
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        flush     = f;
    endtask

    task automatic test_reset();
        bit sawActivity;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        clr_n = 1'b0;
        #1;
        checkCount++;
        if (bus_sel !== 5'd0 || dst_load !== 32'h0 || busy !== 1'b0 || pending !== 3'd0)
            $display("[TB] FAIL reset_init: sel=%0d load=%h busy=%b pend=%0d required 0/0/0/0", bus_sel, dst_load, busy, pending);
        else passCount++;
        tick(); tick();
        clr_n = 1'b1;
        tick();
        checkCount++;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", req_ready);
        else passCount++;
        applyStimulus(1'b1, 5'd7, 32'h8, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        tick(); tick();
        checkCount++;
        if (dst_load !== 32'h8 || bus_sel !== 5'd7)
            $display("[TB] FAIL reset_preload: load=%h sel=%0d required 8/7", dst_load, bus_sel);
        else passCount++;
        clr_n = 1'b0;
        #1;
        checkCount++;
        if (bus_sel !== 5'd0 || dst_load !== 32'h0 || busy !== 1'b0 || pending !== 3'd0)
            $display("[TB] FAIL reset_midload: sel=%0d load=%h busy=%b pend=%0d required 0/0/0/0", bus_sel, dst_load, busy, pending);
        else passCount++;
        tick();
        clr_n = 1'b1;
        sawActivity = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dst_load !== 32'h0 || busy !== 1'b0) sawActivity = 1'b1;
        end
        checkCount++;
        if (sawActivity || req_ready !== 1'b1)
            $display("[TB] FAIL reset_noreplay: activity=%b ready=%b required 0/1", sawActivity, req_ready);
        else passCount++;
    endtask

    task automatic test_single();
        applyStimulus(1'b1, 5'd5, 32'h0000_0004, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkCount++;
        if (pending !== 3'd1 || busy !== 1'b0)
            $display("[TB] FAIL single_accept: pend=%0d busy=%b required 1/0", pending, busy);
        else passCount++;
        tick();
        checkCount++;
        if (bus_sel !== 5'd5 || dst_load !== 32'h0 || busy !== 1'b1)
            $display("[TB] FAIL single_drive: sel=%0d load=%h busy=%b required 5/0/1", bus_sel, dst_load, busy);
        else passCount++;
        tick();
        checkCount++;
        if (bus_sel !== 5'd5 || dst_load !== 32'h4 || busy !== 1'b1)
            $display("[TB] FAIL single_load: sel=%0d load=%h busy=%b required 5/4/1", bus_sel, dst_load, busy);
        else passCount++;
        tick();
        checkCount++;
        if (bus_sel !== 5'd5 || dst_load !== 32'h0 || busy !== 1'b0)
            $display("[TB] FAIL single_idle: sel=%0d load=%h busy=%b required 5/0/0", bus_sel, dst_load, busy);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  pushSrc [3] = '{5'd3, 5'd17, 5'd31};
        logic [31:0] pushDst [3] = '{32'h1, 32'h30, 32'h8000_0000};
        logic [4:0]  expSel  [8] = '{5'd5, 5'd3, 5'd3, 5'd17, 5'd17, 5'd31, 5'd31, 5'd31};
        logic [31:0] expLoad [8] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h30, 32'h0, 32'h8000_0000, 32'h0};
        logic [2:0]  expPend [8] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        logic        expBusy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i < 3) applyStimulus(1'b1, pushSrc[i], pushDst[i], 1'b0);
            else       applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
            tick();
            checkCount++;
            if (bus_sel !== expSel[i] || dst_load !== expLoad[i] || pending !== expPend[i] || busy !== expBusy[i])
                $display("[TB] FAIL b2b_cycle%0d: sel=%0d load=%h pend=%0d busy=%b required %0d/%h/%0d/%b",
                         i, bus_sel, dst_load, pending, busy, expSel[i], expLoad[i], expPend[i], expBusy[i]);
            else passCount++;
        end
    endtask

    task automatic test_full_wrap();
        int          pushed = 0;
        int          nLoads = 0;
        bit          sawFull = 1'b0;
        bit          readyBefore;
        logic [4:0]  selRec  [10];
        logic [31:0] loadRec [10];
        for (int cyc = 0; cyc < 200 && nLoads < 10; cyc++) begin
            if (pushed < 10) applyStimulus(1'b1, 5'(10 + pushed), 32'(1) << pushed, 1'b0);
            else             applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
            readyBefore = req_ready;
            tick();
            if (req_valid && readyBefore) pushed++;
            if (pending === 3'd4 && req_ready === 1'b0) sawFull = 1'b1;
            if (dst_load !== 32'h0) begin
                selRec[nLoads]  = bus_sel;
                loadRec[nLoads] = dst_load;
                nLoads++;
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        checkCount++;
        if (!sawFull) $display("[TB] FAIL full_seen: got 0 required pend=4 with ready=0");
        else passCount++;
        checkCount++;
        if (nLoads != 10) $display("[TB] FAIL wrap_count: got %0d loads required 10", nLoads);
        else passCount++;
        for (int i = 0; i < nLoads; i++) begin
            checkCount++;
            if (selRec[i] !== 5'(10 + i) || loadRec[i] !== (32'(1) << i))
                $display("[TB] FAIL wrap_order%0d: sel=%0d load=%h required %0d/%h",
                         i, selRec[i], loadRec[i], 10 + i, 32'(1) << i);
            else passCount++;
        end
    endtask

    task automatic test_flush();
        bit sawActivity;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 32'h100 << i, 1'b0);
            tick();
        end
        checkCount++;
        if (bus_sel !== 5'd22 || pending !== 3'd3 || busy !== 1'b1 || dst_load !== 32'h0)
            $display("[TB] FAIL flush_setup: sel=%0d pend=%0d busy=%b load=%h required 22/3/1/0", bus_sel, pending, busy, dst_load);
        else passCount++;
        applyStimulus(1'b1, 5'd30, 32'hFFFF_FFFF, 1'b1);
        checkCount++;
        if (req_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %b required 1", req_ready);
        else passCount++;
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkCount++;
        if (busy !== 1'b0 || pending !== 3'd0 || dst_load !== 32'h0 || bus_sel !== 5'd22)
            $display("[TB] FAIL flush_idle: busy=%b pend=%0d load=%h sel=%0d required 0/0/0/22", busy, pending, dst_load, bus_sel);
        else passCount++;
        sawActivity = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dst_load !== 32'h0 || busy !== 1'b0 || pending !== 3'd0) sawActivity = 1'b1;
        end
        checkCount++;
        if (sawActivity) $display("[TB] FAIL flush_cancel: got activity after flush required none");
        else passCount++;
    endtask

    task automatic test_zero_dst();
        bit sawBusy;
        applyStimulus(1'b1, 5'd9, 32'h0, 1'b0);
        checkCount++;
        if (req_ready !== 1'b1) $display("[TB] FAIL zero_ready: got %b required 1", req_ready);
        else passCount++;
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkCount++;
        if (pending !== 3'd0 || busy !== 1'b0)
            $display("[TB] FAIL zero_pending: pend=%0d busy=%b required 0/0", pending, busy);
        else passCount++;
        sawBusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || dst_load !== 32'h0) sawBusy = 1'b1;
        end
        checkCount++;
        if (sawBusy || bus_sel !== 5'd22)
            $display("[TB] FAIL zero_nocycle: activity=%b sel=%0d required 0/22", sawBusy, bus_sel);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_wrap();
        test_flush();
        test_zero_dst();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Upstream control stage for the 32:1 datapath bus multiplexer. Accepts queued register-transfer requests (one source index, one or more destination load enables) over a valid/ready handshake, buffers them in a small FIFO, and plays each one onto the bus as a two-cycle sequence. The sequence first drives the 5-bit mux select to let the two mux levels settle, then pulses the destination load enables with the select held.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `NDST`, 32: width of the destination load-enable vector.
- `clk`  in  1  single clock; all state updates on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals `!full`, registered-state only, no combinational path from `req_valid`.
- `req_src`  in  5  bus source index, 0–31.
- `req_dst`  in  NDST  destination load enables; multi-hot allowed.
- `flush`  in  1  synchronous abort: empties FIFO, cancels the in-flight transfer.
- `bus_sel`  out  5  mux select; registered.
- `dst_load`  out  NDST  destination load enables; registered, one-cycle pulse per transfer.
- `busy`  out  1  high while in DRIVE or LOAD.
- `pending`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. Fields are sampled that edge. The requester may change them the following cycle.
- Requests with `req_dst == 0` are accepted but never enqueued, and produce no bus cycle.
- FSM states:
  - IDLE: `busy=0`, `dst_load=0`, `bus_sel` holds its last value. If the FIFO is non-empty, pop the head and go to DRIVE.
  - DRIVE: `bus_sel=src` of the popped entry, `dst_load=0`, `busy=1`. Go to LOAD.
  - LOAD: `bus_sel` held, `dst_load=dst`, `busy=1`. If the FIFO is non-empty, pop and go to DRIVE; otherwise go to IDLE.
- Throughput: one transfer per 2 cycles, back-to-back with no IDLE gap.
- FIFO: circular, pointers wrap modulo DEPTH, with a separate occupancy counter.
  - Simultaneous push and pop leaves `pending` unchanged.
  - A push when full is impossible because `req_ready=0`.
  - There is no bypass: an empty FIFO still costs one cycle before DRIVE.
- `flush` has priority over everything in the same cycle:
  - Next state is IDLE and `pending` becomes 0.
  - Any concurrent push is discarded, and `req_ready` is still reported from pre-flush state.
  - `dst_load` is forced to 0 on the next edge.
  - If `flush` is asserted during LOAD, the `dst_load` already on the outputs that cycle completes, since it is registered.
- Reset (`clr_n=0`, asynchronous):
  - State IDLE, `bus_sel=5'd0`, `dst_load=0`, `busy=0`, `pending=0`, FIFO pointers 0.
  - An in-flight transfer is lost.
  - `req_ready=1` after release.

## Timing
- A request accepted at edge E into an empty FIFO while IDLE:
  - `pending=1` after E.
  - IDLE pop at E+1, so DRIVE is visible after E+1 with `bus_sel=src`.
  - LOAD is visible after E+2 with `dst_load=dst`.
  - The destination register captures the bus at E+3.
- `req_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after a pop.
- All outputs come directly from flops; there is no combinational input-to-output path.

## Structure
- Shared package `bus_pkg`:
  - `BUS_SEL_W=5`.
  - FSM state enum `{ST_IDLE, ST_DRIVE, ST_LOAD}`.
  - Request struct `{src[4:0], dst[NDST-1:0]}`.
- Sub-module `bus_req_fifo`: parameterised synchronous FIFO with `push`, `pop`, `flush`, `full`, `empty`, `count`.
- The sequencer instantiates one `bus_req_fifo` plus the FSM and output registers.

## Test plan
- Reset:
  - Stimulus: assert `clr_n=0` mid-LOAD with `dst_load=32'h8`.
  - Required response: outputs immediately go to `bus_sel=0`, `dst_load=0`, `busy=0`, `pending=0`. After release, `req_ready=1` and no stale transfer replays.
- Single transfer:
  - Stimulus: push src=5, dst=32'h0000_0004 at edge E.
  - Required response: `bus_sel=5` after E+1, `dst_load=32'h4` for exactly one cycle after E+2, then IDLE with `bus_sel` still 5.
- Back-to-back:
  - Stimulus: push {src=3, dst=0x1}, {src=17, dst=0x30}, {src=31, dst=0x8000_0000} on consecutive edges.
  - Required response: the sel/load sequence 3/0x1, 17/0x30, 31/0x8000_0000 at 2-cycle spacing with no gap. Peak `pending=2`.
- Full and wrap-around:
  - Stimulus: hold the sequencer busy and push 4 requests; then `req_valid` stays high.
  - Required response: `req_ready=0` with `pending=4`. After pops, 6 more requests complete in order across the pointer wrap.
- Flush:
  - Stimulus: with 3 entries pending and in DRIVE, assert `flush` together with a push.
  - Required response: next cycle IDLE, `pending=0`, `dst_load` never pulses for the cancelled or pushed entries.
- Zero destination:
  - Stimulus: push src=9, dst=0.
  - Required response: accepted (`req_ready` seen high), `pending` unchanged, `busy` stays 0.
